// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between NUM_REQ byte sources.
// A granted source holds the transmitter until its last byte, or until it stalls for TIMEOUT cycles.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       abort
);

  localparam int DATA_W = 8;
  localparam int GW     = $clog2(NUM_REQ);
  localparam int CW     = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [GW-1:0]     last_grant;
  logic              locked;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic [CW-1:0]     stall_cnt;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  // First requester strictly after 'last', wrapping around; 'last' itself has lowest priority.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic          found;
    pick  = last;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && v[i] && (GW'(i) > last)) begin
        pick  = GW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && v[i] && (GW'(i) <= last)) begin
        pick  = GW'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[8*i +: 8];
        req_ready[i] = (state == LOAD) && req_valid[i];
      end
    end
  end

  assign tx_valid = (state == SEND);
  assign tx_data  = hold_data;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      locked     <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      stall_cnt  <= '0;
      abort      <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id  <= rr_pick(req_valid, last_grant);
            locked    <= 1'b0;
            stall_cnt <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            hold_data <= sel_data;
            hold_last <= sel_last;
            stall_cnt <= '0;
            state     <= SEND;
          end else if (!locked) begin
            state <= IDLE;
          end else if (stall_cnt == CNT_LAST) begin
            // Stalled mid-packet too long: revoke and demote this source.
            state      <= IDLE;
            last_grant <= grant_id;
            abort      <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (hold_last) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end else begin
              state  <= LOAD;
              locked <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized packet
// traffic checked against a packet-level round-robin reference model.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        abort;

  int checks = 0;
  int errors = 0;

  // Per-source byte streams for the traffic engine
  logic [7:0] pb [4][16];
  logic       pl [4][16];
  int         nbytes [4];
  int         st [4];
  int         rp [4];
  int         exp_src [64];
  logic [7:0] exp_dat [64];
  int         exp_n;

  uart_tx_scheduler #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_sources();
    for (int s = 0; s < 4; s++) begin
      nbytes[s] = 0;
      st[s]     = 0;
    end
    exp_n = 0;
  endtask

  // Packet-level round-robin: every source with pending packets is always requesting.
  task automatic build_rr_model();
    int mp [4];
    int last;
    bit found;
    bit fin;
    int s;
    for (int k = 0; k < 4; k++) mp[k] = 0;
    last  = 3;
    exp_n = 0;
    do begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        s = (last + k) % 4;
        if (!found && mp[s] < nbytes[s]) begin
          do begin
            exp_src[exp_n] = s;
            exp_dat[exp_n] = pb[s][mp[s]];
            fin = pl[s][mp[s]];
            exp_n++;
            mp[s]++;
          end while (!fin);
          last  = s;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  task automatic run_traffic(input int rdy_pct, input string name);
    int  obs;
    int  owner;
    int  aborts;
    bit  done;
    bit  all_used;
    obs = 0; owner = -1; aborts = 0; done = 1'b0;
    for (int s = 0; s < 4; s++) rp[s] = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      for (int s = 0; s < 4; s++) begin
        req_valid[s]        = (cyc >= st[s]) && (rp[s] < nbytes[s]);
        req_data[8*s +: 8]  = (rp[s] < nbytes[s]) ? pb[s][rp[s]] : 8'h00;
        req_last[s]         = (rp[s] < nbytes[s]) ? pl[s][rp[s]] : 1'b0;
      end
      tx_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (abort) aborts++;
      for (int s = 0; s < 4; s++) begin
        if (req_valid[s] && req_ready[s]) begin
          checks++;
          if ((owner != -1 && owner != s) || $countones(req_ready) != 1) begin
            errors++;
            $display("FAIL %s lock: src %0d accepted, req_ready=%b, packet owner %0d", name, s, req_ready, owner);
          end
          owner = pl[s][rp[s]] ? -1 : s;
          rp[s]++;
        end
      end
      if (tx_valid && tx_ready) begin
        checks++;
        if (obs >= exp_n) begin
          errors++;
          $display("FAIL %s extra byte: got src %0d data %h, expected none", name, grant_id, tx_data);
        end else if (tx_data !== exp_dat[obs] || int'(grant_id) != exp_src[obs]) begin
          errors++;
          $display("FAIL %s byte %0d: got src %0d data %h, expected src %0d data %h",
                   name, obs, grant_id, tx_data, exp_src[obs], exp_dat[obs]);
        end
        obs++;
      end
      step();
      all_used = 1'b1;
      for (int s = 0; s < 4; s++) if (rp[s] < nbytes[s]) all_used = 1'b0;
      done = all_used && (obs >= exp_n) && !busy;
    end
    req_valid = '0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: %0d of %0d bytes seen, busy=%b", name, obs, exp_n, busy);
    end
    checks++;
    if (obs !== exp_n) begin
      errors++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, obs, exp_n);
    end
    checks++;
    if (aborts !== 0) begin
      errors++;
      $display("FAIL %s abort: got %0d pulses, expected 0", name, aborts);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = 32'hDEADBEEF; req_last = 4'hF; tx_ready = 1'b1;
    step();
    step();
    checks++;
    if ({tx_valid, tx_data, req_ready, grant_id, busy, abort} !== 16'h0) begin
      errors++;
      $display("FAIL reset: tx_valid=%b tx_data=%h req_ready=%b grant_id=%0d busy=%b abort=%b, expected all 0",
               tx_valid, tx_data, req_ready, grant_id, busy, abort);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_data = 32'h0000_0041; req_last = 4'b0001; tx_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single c0: busy=%b req_ready=%b, expected 0 0000", busy, req_ready);
    end
    step();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single c1: busy=%b grant=%0d req_ready=%b tx_valid=%b, expected 1 0 0001 0",
               busy, grant_id, req_ready, tx_valid);
    end
    step();
    req_valid = '0;
    #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single c2: tx_valid=%b tx_data=%h req_ready=%b, expected 1 41 0000", tx_valid, tx_data, req_ready);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL single c3: busy=%b tx_valid=%b grant=%0d tx_data=%h, expected 0 0 0 41",
               busy, tx_valid, grant_id, tx_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_sources();
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 2; p++) begin
        pb[s][p] = 8'(8'h20 + 16 * p + s);
        pl[s][p] = 1'b1;
      end
      nbytes[s] = 2;
    end
    build_rr_model();
    run_traffic(100, "round_robin");
  endtask

  task automatic test_packet_lock();
    do_reset();
    clear_sources();
    pb[2][0] = 8'h10; pl[2][0] = 1'b0;
    pb[2][1] = 8'h11; pl[2][1] = 1'b0;
    pb[2][2] = 8'h12; pl[2][2] = 1'b1;
    nbytes[2] = 3;
    pb[0][0] = 8'h99; pl[0][0] = 1'b1;
    nbytes[0] = 1;
    st[0] = 2;
    exp_src[0] = 2; exp_dat[0] = 8'h10;
    exp_src[1] = 2; exp_dat[1] = 8'h11;
    exp_src[2] = 2; exp_dat[2] = 8'h12;
    exp_src[3] = 0; exp_dat[3] = 8'h99;
    exp_n = 4;
    run_traffic(100, "packet_lock");
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    req_valid = 4'b0110; req_data = 32'h00A5_5500; req_last = 4'b0100; tx_ready = 1'b1;
    step();
    checks++;
    if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL timeout grant: grant=%0d req_ready=%b, expected 1 0010", grant_id, req_ready);
    end
    step();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
      errors++;
      $display("FAIL timeout send: tx_valid=%b tx_data=%h, expected 1 55", tx_valid, tx_data);
    end
    step();
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (abort !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL timeout stall: %0d bad stall cycles, expected 0", bad);
    end
    checks++;
    if (abort !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout abort: abort=%b busy=%b, expected 1 0", abort, busy);
    end
    step();
    checks++;
    if (abort !== 1'b0 || grant_id !== 2'd2 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL timeout regrant: abort=%b grant=%0d req_ready=%b, expected 0 2 0100", abort, grant_id, req_ready);
    end
    step();
    req_valid = '0;
    #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL timeout next byte: tx_valid=%b tx_data=%h, expected 1 a5", tx_valid, tx_data);
    end
    step();
  endtask

  task automatic test_tx_stall();
    int bad;
    do_reset();
    req_valid = 4'b0011; req_data = 32'h0000_773C; req_last = 4'b0011; tx_ready = 1'b0;
    step();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall grant: req_ready=%b, expected 0001", req_ready);
    end
    step();
    req_valid = 4'b0010;
    #1;
    bad = 0;
    for (int k = 0; k < 5000; k++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h3C || req_ready !== 4'b0000 || abort !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall hold: %0d unstable cycles, expected 0", bad);
    end
    tx_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall release: busy=%b tx_valid=%b, expected 0 0", busy, tx_valid);
    end
    step();
    checks++;
    if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall next: grant=%0d req_ready=%b, expected 1 0010", grant_id, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_in_send();
    int sent;
    do_reset();
    req_valid = 4'b0001; req_data = 32'h0000_007E; req_last = 4'b0001; tx_ready = 1'b0;
    step();
    step();
    req_valid = '0;
    #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h7E) begin
      errors++;
      $display("FAIL rst_send pre: tx_valid=%b tx_data=%h, expected 1 7e", tx_valid, tx_data);
    end
    rst = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_send post: tx_valid=%b busy=%b tx_data=%h, expected 0 0 00", tx_valid, busy, tx_data);
    end
    rst = 1'b0;
    tx_ready = 1'b1;
    sent = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid) sent++;
      step();
    end
    checks++;
    if (sent !== 0) begin
      errors++;
      $display("FAIL rst_send resend: %0d tx_valid cycles, expected 0", sent);
    end
  endtask

  task automatic test_random_traffic();
    int np;
    int len;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      clear_sources();
      for (int s = 0; s < 4; s++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            pb[s][nbytes[s]] = 8'($urandom);
            pl[s][nbytes[s]] = (b == len - 1);
            nbytes[s]++;
          end
        end
      end
      build_rr_model();
      run_traffic(60, "random");
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_tx_stall();
    test_reset_in_send();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
